// File: rtl/cache_port_arbiter.sv
// Two-port round-robin arbiter in front of the single cache port: latches the
// winner's command, issues it for one cycle, waits for completion or timeout, returns it.
module cache_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             wr0,
    input  logic             wr1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [DW-1:0]    wdata0,
    input  logic [DW-1:0]    wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err0,
    output logic             err1,
    output logic [DW-1:0]    rdata0,
    output logic [DW-1:0]    rdata1,
    output logic             c_req,
    output logic             c_write,
    output logic [AW-1:0]    c_addr,
    output logic [DW-1:0]    c_wdata,
    input  logic             c_done,
    input  logic             c_hit,
    input  logic [DW-1:0]    c_rdata,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic            owner;
    logic            last_grant;
    logic            to_flag;
    logic            hit_q;
    logic [DW-1:0]   rdata_q;
    logic [TW-1:0]   tcnt;
    logic            pick1;

    // Handshake: a requester holds reqN until gntN pulses; the grant cycle
    // is the only point where its wr/addr/wdata are sampled. doneN (with errN
    // on timeout) pulses once per granted request, rdataN valid only with it.
    always_comb begin
        pick1 = req1 & (~req0 | ~last_grant);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            to_flag    <= 1'b0;
            hit_q      <= 1'b0;
            rdata_q    <= '0;
            tcnt       <= '0;
            c_write    <= 1'b0;
            c_addr     <= '0;
            c_wdata    <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner   <= pick1;
                        c_write <= pick1 ? wr1 : wr0;
                        c_addr  <= pick1 ? addr1 : addr0;
                        c_wdata <= pick1 ? wdata1 : wdata0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (c_done) begin
                        rdata_q <= c_rdata;
                        hit_q   <= c_hit;
                        to_flag <= 1'b0;
                        state   <= RESP;
                    end else if (tcnt == T_LAST) begin
                        rdata_q <= '0;
                        hit_q   <= 1'b0;
                        to_flag <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    last_grant <= owner;
                    tcnt       <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Clear wins over a same-cycle increment; timeouts are not counted.
            if (clr_cnt) begin
                hit_cnt  <= '0;
                miss_cnt <= '0;
            end else if (state == RESP && !to_flag) begin
                if (hit_q && hit_cnt != '1)
                    hit_cnt <= hit_cnt + 1'b1;
                else if (!hit_q && miss_cnt != '1)
                    miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    assign c_req  = (state == ISSUE);
    assign gnt0   = (state == ISSUE) && !owner;
    assign gnt1   = (state == ISSUE) &&  owner;
    assign done0  = (state == RESP)  && !owner;
    assign done1  = (state == RESP)  &&  owner;
    assign err0   = done0 && to_flag;
    assign err1   = done1 && to_flag;
    assign rdata0 = done0 ? rdata_q : '0;
    assign rdata1 = done1 ? rdata_q : '0;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a cache responder, expected-grant and
// expected-response queues checked by negedge monitors, counter checks.
module tb_cache_port_arbiter;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;
    localparam int CMAX    = 255;

    logic        clk;
    logic        reset;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        c_req, c_write;
    logic [31:0] c_addr, c_wdata;
    logic        c_done, c_hit;
    logic [31:0] c_rdata;
    logic        clr_main, clr_resp;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    int          cache_delay  = 1;
    bit          cache_silent = 0;
    logic        cache_hit    = 0;
    logic [31:0] cache_rdata  = 0;
    bit          cache_clr    = 0;

    logic [67:0] gnt_exp_q[$];
    logic [67:0] exp_q[$];

    cache_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .c_req(c_req), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done), .c_hit(c_hit), .c_rdata(c_rdata),
        .clr_cnt(clr_main | clr_resp),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [67:0] exp_gnt(input int p, input logic w, input logic [31:0] a,
                                            input logic [31:0] d);
        return {p == 0, p == 1, 1'b1, w, a, d};
    endfunction

    function automatic logic [67:0] exp_resp(input int p, input logic e, input logic [31:0] rd);
        logic [31:0] r0, r1;
        r0 = (p == 0) ? rd : 32'h0;
        r1 = (p == 1) ? rd : 32'h0;
        return {p == 0, p == 1, e && p == 0, e && p == 1, r0, r1};
    endfunction

    // cache responder: c_done 'cache_delay' cycles after the c_req cycle
    initial begin
        c_done = 0; c_hit = 0; c_rdata = 0; clr_resp = 0;
        forever begin
            @(posedge clk); #1;
            c_done = 0; clr_resp = 0;
            if (c_req && !reset && !cache_silent) begin
                repeat (cache_delay) begin @(posedge clk); #1; end
                c_done = 1; c_hit = cache_hit; c_rdata = cache_rdata;
                @(posedge clk); #1;
                c_done = 0; c_hit = 0; c_rdata = 0;
                clr_resp = cache_clr;
            end
        end
    end

    // scoreboard monitors
    always @(negedge clk) begin
        if (!reset && (gnt0 || gnt1)) begin
            if (gnt_exp_q.size() == 0)
                check("gnt_unexpected", 128'({gnt0, gnt1}), 128'(0));
            else
                check("gnt", 128'({gnt0, gnt1, c_req, c_write, c_addr, c_wdata}),
                      128'(gnt_exp_q.pop_front()));
        end
        if (!reset && (done0 || done1 || err0 || err1)) begin
            if (exp_q.size() == 0)
                check("resp_unexpected", 128'({done0, done1, err0, err1}), 128'(0));
            else
                check("resp", 128'({done0, done1, err0, err1, rdata0, rdata1}),
                      128'(exp_q.pop_front()));
        end
    end

    task automatic drive_port(input int p, input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d);
        if (p == 0) begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit_cnt"}, 128'(hit_cnt), 128'(exp_hit));
        check({tag, "_miss_cnt"}, 128'(miss_cnt), 128'(exp_miss));
    endtask

    // dly=0: cache never answers (timeout). tie: other port requests too.
    task automatic run_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int dly, input logic hit, input logic [31:0] rd,
                           input bit tie, input bit clr, input bit abandon);
        int cnt;
        logic seen;
        cache_delay = dly; cache_silent = (dly == 0); cache_hit = hit;
        cache_rdata = rd; cache_clr = clr;
        gnt_exp_q.push_back(exp_gnt(p, w, a, d));
        if (!abandon) exp_q.push_back(exp_resp(p, dly == 0, (dly == 0) ? 32'h0 : rd));
        @(posedge clk); #1;
        drive_port(p, 1'b1, w, a, d);
        if (tie) drive_port(1 - p, 1'b1, ~w, a ^ 32'h0000_0FF0, ~d);
        cnt = 0; seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk); cnt++;
            seen = (p == 0) ? gnt0 : gnt1;
        end
        check("gnt_latency", 128'(cnt), 128'(2));
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b1, 32'hBAD0_0000, 32'hFFFF_FFFF);
        drive_port(1, 1'b0, 1'b0, 32'hBAD1_1111, 32'h0000_0001);
        if (abandon) return;
        cnt = 0; seen = 0;
        while (!seen && cnt < TIMEOUT + 20) begin
            @(negedge clk); cnt++;
            check("cbus_hold", 128'({c_req, c_write, c_addr, c_wdata}), 128'({1'b0, w, a, d}));
            seen = (p == 0) ? done0 : done1;
        end
        check("done_latency", 128'(cnt), 128'((dly > 0) ? dly + 1 : TIMEOUT + 1));
        if (clr) begin
            exp_hit = 0; exp_miss = 0;
        end else if (dly > 0) begin
            if (hit) begin if (exp_hit < CMAX) exp_hit++; end
            else begin if (exp_miss < CMAX) exp_miss++; end
        end
        cache_clr = 0;
        @(negedge clk);
        check_counters("txn");
    endtask

    initial begin
        int ng, cnt;
        reset = 1; clr_main = 0;
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_ctrl", 128'({gnt0, gnt1, done0, done1, err0, err1, c_req, c_write,
                                   hit_cnt, miss_cnt}), 128'(0));
        check("reset_bus", 128'({c_addr, c_wdata, rdata0, rdata1}), 128'(0));

        // single read hit on port 0
        run_txn(0, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 0, 0, 0);
        // write miss on port 1 with a slow cache
        run_txn(1, 1'b1, 32'h40, 32'h5A5A_5A5A, 10, 1'b0, 32'h0BAD_F00D, 0, 0, 0);

        // both ports held high: grants alternate starting with port 0
        cache_delay = 1; cache_silent = 0; cache_hit = 1; cache_rdata = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            gnt_exp_q.push_back(exp_gnt(i % 2, (i % 2) == 1, (i % 2) ? 32'h300 : 32'h200,
                                        (i % 2) ? 32'h77 : 32'h0));
            exp_q.push_back(exp_resp(i % 2, 1'b0, 32'h1111_2222));
        end
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b0, 32'h200, 32'h0);
        drive_port(1, 1'b1, 1'b1, 32'h300, 32'h77);
        ng = 0; cnt = 0;
        while (ng < 4 && cnt < 100) begin
            @(negedge clk); cnt++;
            if (gnt0 || gnt1) ng++;
        end
        check("alt_grants", 128'(ng), 128'(4));
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        cnt = 0;
        while (!(done0 || done1) && cnt < 20) begin @(negedge clk); cnt++; end
        check("alt_done_seen", 128'(done0 || done1), 128'(1));
        exp_hit += 4;
        @(negedge clk);
        check_counters("alt");

        // timeout, then completion on the very last WAIT cycle
        run_txn(0, 1'b0, 32'h80, 32'h0, 0, 1'b1, 32'hFFFF_0000, 0, 0, 0);
        run_txn(0, 1'b0, 32'h84, 32'h0, TIMEOUT, 1'b1, 32'hCAFE_0001, 0, 0, 0);

        // reset in the middle of WAIT abandons the transaction
        run_txn(0, 1'b1, 32'h1234, 32'h55, 0, 1'b0, 32'h0, 0, 0, 1);
        repeat (5) @(negedge clk);
        #2 reset = 1;
        #1;
        check("midreset_ctrl", 128'({gnt0, gnt1, done0, done1, err0, err1, c_req, c_write,
                                      hit_cnt, miss_cnt}), 128'(0));
        check("midreset_bus", 128'({c_addr, c_wdata, rdata0, rdata1}), 128'(0));
        repeat (3) begin
            @(negedge clk);
            check("reset_quiet", 128'({gnt0, gnt1, done0, done1, c_req}), 128'(0));
        end
        @(posedge clk); #1 reset = 0;
        exp_hit = 0; exp_miss = 0;
        // last grant was port 0, but reset restores port-0 priority on a tie
        run_txn(0, 1'b0, 32'h300, 32'h0, 1, 1'b1, 32'h1357_2468, 1, 0, 0);

        // saturation of hit_cnt
        @(posedge clk); #1 clr_main = 1;
        @(posedge clk); #1 clr_main = 0;
        exp_hit = 0; exp_miss = 0;
        @(negedge clk);
        check_counters("clr");
        for (int i = 0; i < CMAX; i++)
            run_txn(i % 2, 1'b0, 32'h1000 + i, 32'h0, 1, 1'b1, 32'h0000_1000 + i, 0, 0, 0);
        check("hit_full", 128'(hit_cnt), 128'(8'hFF));
        run_txn(0, 1'b0, 32'h2000, 32'h0, 2, 1'b1, 32'hA0A0_A0A0, 0, 0, 0);
        check("hit_saturated", 128'(hit_cnt), 128'(8'hFF));
        // clear asserted in the RESP cycle beats the increment
        run_txn(1, 1'b0, 32'h2004, 32'h0, 1, 1'b1, 32'hB0B0_B0B0, 0, 1, 0);
        check("clr_on_resp", 128'(hit_cnt), 128'(0));

        repeat (4) @(negedge clk);
        check("gnt_queue_empty", 128'(gnt_exp_q.size()), 128'(0));
        check("resp_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
